// File: rtl/pair_triple_framer_pkg.sv
// pair_triple_framer_pkg: shared state encoding and default counter width
package pair_triple_framer_pkg;
  localparam logic [1:0] STATE_FILL = 2'd0;
  localparam logic [1:0] STATE_EVAL = 2'd1;
  localparam logic [1:0] STATE_OUT  = 2'd2;
  localparam int COUNT_W_DEF = 8;
endpackage

// File: rtl/pair_triple_framer_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = clr ? '0 : (inc && count_q != '1) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk) count_q <= rst ? '0 : count_d;
  assign count = count_q;
endmodule

// File: rtl/pair_triple_framer.sv
// pair_triple_framer: packs serial bits into 3-bit frames and returns detector verdicts
module pair_triple_framer
  import pair_triple_framer_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF,
  parameter bit DET_INV = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic               in_bit,
  output logic [2:0]         frame,
  input  logic               det_in,
  output logic               out_val,
  input  logic               out_rdy,
  output logic               out_result,
  output logic [COUNT_W-1:0] frame_count,
  output logic [COUNT_W-1:0] hit_count
);
  logic [1:0] state_q, state_d, idx_q, idx_d;
  logic [2:0] frame_q, frame_d;
  logic       result_q, result_d;
  logic       in_xfer, out_xfer;
  assign in_rdy   = state_q == STATE_FILL;
  assign out_val  = state_q == STATE_OUT;
  assign in_xfer  = in_val & in_rdy;
  assign out_xfer = out_val & out_rdy;
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    frame_d  = frame_q;
    result_d = result_q;
    case (state_q)
      STATE_FILL: if (in_xfer) begin
        frame_d[idx_q] = in_bit;
        idx_d   = idx_q == 2'd2 ? 2'd0 : idx_q + 2'd1;
        state_d = idx_q == 2'd2 ? STATE_EVAL : STATE_FILL;
      end
      STATE_EVAL: begin
        result_d = det_in ^ DET_INV;
        state_d  = STATE_OUT;
      end
      STATE_OUT: if (out_xfer) begin
        frame_d = 3'b000;
        state_d = STATE_FILL;
      end
      default: begin
        state_d = STATE_FILL;
        idx_d   = 2'd0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    state_q  <= rst ? STATE_FILL : state_d;
    idx_q    <= rst ? 2'd0 : idx_d;
    frame_q  <= rst ? 3'b000 : frame_d;
    result_q <= rst ? 1'b0 : result_d;
  end
  assign frame      = frame_q;
  assign out_result = result_q;
  sat_counter #(.W(COUNT_W)) u_frame_cnt (
    .clk(clk), .rst(rst), .clr(clr), .inc(out_xfer), .count(frame_count)
  );
  sat_counter #(.W(COUNT_W)) u_hit_cnt (
    .clk(clk), .rst(rst), .clr(clr), .inc(out_xfer & result_q), .count(hit_count)
  );
endmodule

// File: doc/pair_triple_framer.md
Name: pair_triple_framer

Overview:
- Sequential front-end for the three-input pair/triple detector.
- Accepts a serial bit stream over a val/rdy handshake and packs every three accepted bits into a frame.
- Drives each frame combinationally into the detector and captures the detector's 1-bit verdict.
- Emits the verdict over a val/rdy output handshake and keeps saturating counts of frames and hits.

Parameters:
- COUNT_W, 8, width of the frame and hit counters.
- DET_INV, 0, 1 = invert the captured detector verdict (for an active-low detector output).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- clr  input  1  synchronous clear of both counters only
- in_val  input  1  serial bit valid
- in_rdy  output  1  framer can accept a bit
- in_bit  input  1  serial data bit
- frame  output  3  packed frame to detector; frame[0] = first bit accepted
- det_in  input  1  detector verdict for the current frame (combinational from frame)
- out_val  output  1  verdict valid
- out_rdy  input  1  consumer ready
- out_result  output  1  registered verdict (det_in ^ DET_INV)
- frame_count  output  COUNT_W  saturating count of delivered frames
- hit_count  output  COUNT_W  saturating count of delivered verdicts equal to 1

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values:
  - state = FILL, idx = 0, frame = 3'b000, out_result = 0
  - out_val = 0, frame_count = 0, hit_count = 0
  - rst overrides clr and every handshake.
- Transfer rules:
  - Input transfer when in_val & in_rdy.
  - Output transfer when out_val & out_rdy.
  - Signals are sampled at the rising edge.
- FILL state:
  - in_rdy = 1, out_val = 0.
  - On an input transfer: frame[idx] <= in_bit, idx <= idx + 1.
  - Transfer with idx == 2: idx <= 0, next state = EVAL.
  - in_val low: hold all state.
- EVAL state (exactly one cycle):
  - in_rdy = 0, out_val = 0; frame is stable and complete.
  - out_result <= det_in ^ DET_INV; next state = OUT.
- OUT state:
  - in_rdy = 0, out_val = 1; out_result and frame held.
  - On an output transfer:
    - frame_count += 1
    - hit_count += out_result
    - frame <= 3'b000
    - next state = FILL
  - out_rdy low: remain in OUT indefinitely, no counter change.
- Latency: third bit accepted on edge T; EVAL during cycle T+1; out_val high during cycle T+2. The minimum frame period is 5 cycles.
- No bit is accepted during EVAL or OUT (no overlap). The upstream source must tolerate in_rdy = 0 for at least 2 cycles per frame.
- Counters:
  - Both saturate at 2^COUNT_W - 1; further increments are ignored.
  - clr zeroes both counters on the next edge.
  - clr coincident with an output transfer: the counters read 0 after the edge (clr wins), but the transfer still completes and the state still returns to FILL.
- Partial frame plus rst: idx and frame are cleared and the partial bits are discarded.
- Partial frame plus clr: the frame is unaffected.
- State encoding: 2 bits. The unused code 2'b11 returns to FILL with idx = 0 on the next edge.
- Outputs depend only on state and registers; no combinational path from in_val or out_rdy to any output.

Decomposition:
- Shared package/include holds:
  - state constants STATE_FILL = 2'd0, STATE_EVAL = 2'd1, STATE_OUT = 2'd2
  - default COUNT_W
- One sub-module, sat_counter (params W; ports clk, rst, clr, inc, count). It is instantiated twice: frame counter (inc = output transfer) and hit counter (inc = output transfer & out_result).
- FSM, shift/index logic and result register stay in the top module.

Test Plan:
- Reset then bits 1,1,0 with in_val held high, detector model = at-least-two-of-three, out_rdy = 1 -> frame = 3'b011 in EVAL; out_val = 1 two cycles after the third bit; out_result = 1; frame_count = 1; hit_count = 1.
- Bits 1,0,0 with out_rdy = 0 for 4 cycles -> out_val stays 1 and out_result = 0 throughout; in_rdy = 0; counters unchanged until out_rdy rises; then frame_count += 1 and hit_count unchanged.
- in_val gapped (bit, idle 2 cycles, bit, idle, bit) -> idle cycles do not advance idx; frame = the three bits in order; exactly one verdict.
- Two bits accepted, then rst pulse, then bits 0,1,1 -> the first partial frame is discarded; the single verdict is for 3'b110.
- COUNT_W = 2, five all-ones frames delivered -> frame_count and hit_count saturate at 3; clr coincident with the sixth output transfer -> both read 0 and the state returns to FILL.
- DET_INV = 1 with frame 1,1,1 -> out_result = 0, hit_count unchanged, frame_count += 1.
